wave_gen: RTL and testbench

WAVE_GEN -- requirements
Module: wave_gen

---
 rtl/wave_gen.sv | 126 ++++++++++++
 tb/tb_wave_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen.sv
// wave_gen: phase-accumulator waveform generator with a glitch-free config handshake.
//
// A phase accumulator advances by inc_a on each enabled cycle. The top bits of
// the next accumulator value are shaped into a saw-up, saw-down, triangle or
// square sample. New configuration is parked in pending registers and only
// becomes active on a cycle boundary where switching cannot tear a period:
// the accumulator wraps, the generator is paused, or the increment is zero.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   en         in   accumulator advance enable
//   cfg_valid  in   new configuration offered
//   cfg_ready  out  configuration can be accepted (FSM idle)
//   cfg_inc    in   [ACC_BITS] phase increment per enabled cycle
//   cfg_mode   in   [2] 0 saw up, 1 saw down, 2 triangle, 3 square
//   cfg_duty   in   [VAL_BITS] square-mode threshold
//   val        out  [VAL_BITS] registered waveform sample
//   wrap       out  single-cycle pulse when the accumulator wraps
//
// ACC_BITS must be at least VAL_BITS+1 (triangle uses one bit below p).
module wave_gen #(
    parameter int ACC_BITS = 27,
    parameter int VAL_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ACC_BITS-1:0] cfg_inc,
    input  logic [1:0]          cfg_mode,
    input  logic [VAL_BITS-1:0] cfg_duty,
    output logic [VAL_BITS-1:0] val,
    output logic                wrap
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t              state, state_nxt;
    logic [ACC_BITS-1:0] acc, acc_d;
    logic [ACC_BITS:0]   sum;
    logic                carry;
    logic [VAL_BITS-1:0] p, t, f;
    logic                capture, apply;

    // active and pending configuration
    logic [ACC_BITS-1:0] inc_a, inc_p;
    logic [1:0]          mode_a, mode_p;
    logic [VAL_BITS-1:0] duty_a, duty_p;

    // Datapath: next accumulator value and the sample it maps to.
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, inc_a};
        acc_d = en ? sum[ACC_BITS-1:0] : acc;
        carry = en & sum[ACC_BITS];
        p     = acc_d[ACC_BITS-1 -: VAL_BITS];
        t     = acc_d[ACC_BITS-2 -: VAL_BITS];
        case (mode_a)
            2'd0:    f = p;
            2'd1:    f = ~p;
            2'd2:    f = acc_d[ACC_BITS-1] ? ~t : t;
            default: f = (p < duty_a) ? {VAL_BITS{1'b1}} : {VAL_BITS{1'b0}};
        endcase
    end

    // Config FSM: accept in IDLE, apply from PENDING at a safe boundary.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        apply     = 1'b0;
        cfg_ready = (state == IDLE);
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    capture   = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                // Swap only where no period is cut short: at wrap, while
                // paused, or when the accumulator is frozen by a zero step.
                if (carry || !en || (inc_a == '0)) begin
                    apply     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            val    <= '0;
            wrap   <= 1'b0;
            inc_a  <= {{(ACC_BITS-1){1'b0}}, 1'b1};
            mode_a <= 2'd2;
            duty_a <= {1'b1, {(VAL_BITS-1){1'b0}}};
            inc_p  <= '0;
            mode_p <= '0;
            duty_p <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_d;
            wrap  <= carry;
            // While paused the sample stays frozen even if a new mode lands,
            // so the output never changes without the accumulator moving.
            if (en)
                val <= f;
            if (capture) begin
                inc_p  <= cfg_inc;
                mode_p <= cfg_mode;
                duty_p <= cfg_duty;
            end
            // Old config already produced this edge's acc/val/wrap above.
            if (apply) begin
                inc_a  <= inc_p;
                mode_a <= mode_p;
                duty_a <= duty_p;
            end
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed, table-driven bench for wave_gen at ACC_BITS=8, VAL_BITS=4.
module tb_wave_gen;

    localparam int AB = 8;
    localparam int VB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [AB-1:0] cfg_inc = '0;
    logic [1:0]    cfg_mode = '0;
    logic [VB-1:0] cfg_duty = '0;
    logic [VB-1:0] val;
    logic          wrap;

    wave_gen #(.ACC_BITS(AB), .VAL_BITS(VB)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_inc   (cfg_inc),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .val       (val),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          cv;
        logic [AB-1:0] inc;
        logic [1:0]    mode;
        logic [VB-1:0] duty;
        logic [VB-1:0] exp_val;
        logic          exp_wrap;
        logic          exp_ready;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic void add(input logic e, input logic c, input logic [AB-1:0] i,
                                input logic [1:0] m, input logic [VB-1:0] d,
                                input logic [VB-1:0] ev, input logic ew, input logic er);
        vec_t v;
        v.en = e; v.cv = c; v.inc = i; v.mode = m; v.duty = d;
        v.exp_val = ev; v.exp_wrap = ew; v.exp_ready = er;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic c, input logic [AB-1:0] i,
                         input logic [1:0] m, input logic [VB-1:0] d);
        en = e; cfg_valid = c; cfg_inc = i; cfg_mode = m; cfg_duty = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Hard stop in case something upstream wedges the clock loop.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int wraps;

        // Saw up after default run leaves acc=0: load, apply while paused, ramp.
        add(0, 1, 8'd16, 2'd0, 4'd0, 4'd0, 0, 0);
        add(0, 0, 8'd0,  2'd0, 4'd0, 4'd0, 0, 1);
        for (int i = 0; i < 16; i++)
            add(1, 0, 0, 0, 0, 4'((i + 1) % 16), (i == 15), 1);
        // Square duty 4: p=1..3 high, p=4..15 low, p=0 (wrap sample) high.
        add(0, 1, 8'd16, 2'd3, 4'd4, 4'd0, 0, 0);
        add(0, 0, 8'd0,  2'd0, 4'd0, 4'd0, 0, 1);
        for (int i = 0; i < 16; i++)
            add(1, 0, 0, 0, 0, (i < 3 || i == 15) ? 4'd15 : 4'd0, (i == 15), 1);

        // ---- reset state ----
        drive(1, 1, 8'd99, 2'd1, 4'd3);
        rst = 1'b1;
        tick();
        chk("rst.val", val, 0);
        chk("rst.wrap", wrap, 0);
        chk("rst.ready", cfg_ready, 1);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0);

        // ---- defaults: triangle, inc 1 ----
        wraps = 0;
        for (int c = 1; c <= 255; c++) begin
            tick();
            if (wrap) wraps++;
            if (c == 16)  chk("dflt.val@16", val, 2);
            if (c == 128) chk("dflt.val@128", val, 15);
            if (c == 255) chk("dflt.val@255", val, 0);
        end
        chk("dflt.no_early_wrap", wraps, 0);
        tick();
        chk("dflt.wrap@256", wrap, 1);
        chk("dflt.val@256", val, 0);
        tick();
        chk("dflt.wrap@257", wrap, 0);
        // acc is now 1; realign to 0 for the table section
        do_reset();
        for (int c = 0; c < 256; c++) begin
            drive(1, 0, 0, 0, 0);
            tick();
        end

        // ---- table: saw up and square ----
        foreach (tbl[k]) begin
            drive(tbl[k].en, tbl[k].cv, tbl[k].inc, tbl[k].mode, tbl[k].duty);
            tick();
            chk($sformatf("tbl[%0d].val", k), val, tbl[k].exp_val);
            chk($sformatf("tbl[%0d].wrap", k), wrap, tbl[k].exp_wrap);
            chk($sformatf("tbl[%0d].ready", k), cfg_ready, tbl[k].exp_ready);
        end

        // ---- deferred apply at wrap ----
        do_reset();
        drive(0, 1, 8'd16, 2'd0, 4'd0); tick();
        drive(0, 0, 0, 0, 0);           tick();
        drive(1, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) tick();
        chk("defer.val@0x50", val, 5);
        drive(1, 1, 8'd32, 2'd1, 4'd0); tick();
        chk("defer.val@0x60", val, 6);
        chk("defer.ready_low", cfg_ready, 0);
        for (int k = 7; k <= 15; k++) begin
            // offers while pending must be dropped
            drive(1, 1, 8'd64, 2'd0, 4'd0);
            tick();
            chk($sformatf("defer.val@%0d", k), val, k);
            chk($sformatf("defer.ready@%0d", k), cfg_ready, 0);
            chk($sformatf("defer.wrap@%0d", k), wrap, 0);
        end
        drive(1, 0, 0, 0, 0); tick();
        chk("defer.wrap_edge", wrap, 1);
        chk("defer.val_wrap", val, 0);
        chk("defer.ready_back", cfg_ready, 1);
        tick();
        chk("defer.new_cfg0", val, 13);
        tick();
        chk("defer.new_cfg1", val, 11);

        // ---- enable hold ----
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold.val[%0d]", c), val, 11);
            chk($sformatf("hold.wrap[%0d]", c), wrap, 0);
        end
        drive(1, 0, 0, 0, 0); tick();
        chk("hold.resume", val, 9);

        // ---- zero increment still applies config ----
        do_reset();
        drive(0, 1, 8'd0, 2'd0, 4'd0); tick();
        drive(0, 0, 0, 0, 0);          tick();
        drive(1, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("zinc.val[%0d]", c), val, 0);
            chk($sformatf("zinc.wrap[%0d]", c), wrap, 0);
        end
        drive(1, 1, 8'd16, 2'd0, 4'd0); tick();
        chk("zinc.ready_low", cfg_ready, 0);
        drive(1, 0, 0, 0, 0); tick();
        chk("zinc.applied", cfg_ready, 1);
        chk("zinc.val_old", val, 0);
        tick();
        chk("zinc.val_new", val, 1);

        // ---- reset while pending ----
        drive(1, 1, 8'd16, 2'd0, 4'd0); tick();
        chk("rstp.ready_low", cfg_ready, 0);
        rst = 1'b1;
        drive(1, 1, 8'd16, 2'd0, 4'd0); tick();
        rst = 1'b0;
        chk("rstp.ready", cfg_ready, 1);
        chk("rstp.val", val, 0);
        chk("rstp.wrap", wrap, 0);
        drive(1, 0, 0, 0, 0);
        wraps = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (!cfg_ready) wraps++;
        end
        chk("rstp.ready_stays", wraps, 0);
        chk("rstp.triangle@16", val, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
